de2i_150_qsys_nios2_cpu_debug_jtag_master: RTL
==============================================

# de2i_150_qsys_nios2_cpu_debug_jtag_master

Host-side driver for the Nios II debug slave's virtual-JTAG port. It accepts one debug command (IR value plus DR payload) on a valid/ready handshake. It then generates the full virtual-JTAG sequence toward the debug slave (UIR, CDR, SDR shift, UDR, RTI) on a divided TCK, and returns the shifted-out DR and the captured IR status. It replaces the hub/PHY in simulation and in test-harness builds, so debug transactions can be scripted without a JTAG cable.

## Interface
Parameters:
- DR_WIDTH, 38: data-register length in bits.
- IR_WIDTH, 2: virtual IR width.
- TCK_DIV, 4: clk cycles per TCK half-period; minimum 1.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_ir  in  IR_WIDTH  IR value for this command.
- cmd_dr  in  DR_WIDTH  DR payload, shifted LSB first.
- cmd_ir_only  in  1  1 = IR update only; CDR, SDR and UDR are skipped.
- rsp_valid  out  1  one-cycle pulse: the response fields are valid.
- rsp_dr  out  DR_WIDTH  DR bits captured from tdo; held until the next response.
- rsp_ir  out  IR_WIDTH  ir_out sampled during UIR; held until the next response.
- tck  out  1  generated TCK.
- tdi  out  1  serial data toward the slave.
- tdo  in  1  serial data from the slave.
- ir_in  out  IR_WIDTH  virtual IR toward the slave.
- ir_out  in  IR_WIDTH  status from the slave.
- vs_uir, vs_cdr, vs_sdr, vs_udr  out  1 each  virtual-state indicators.
- jtag_state_rti  out  1  run-test-idle indicator.

## Operation
- **States:** IDLE, UIR, CDR, SDR, UDR, RTI, DONE.
- **Periods:** every non-IDLE/DONE state occupies whole TCK periods of 2*TCK_DIV clk cycles.
  - tck is low for the first TCK_DIV cycles of a period and high for the last TCK_DIV cycles.
  - State changes and output changes happen only at period boundaries, which coincide with the TCK falling edge.
- **IDLE:**
  - cmd_ready=1, tck=0, all vs_* indicators = 0.
  - A command is accepted when cmd_valid && cmd_ready.
  - On acceptance: latch cmd_ir into ir_in, latch cmd_dr into the shift register, cmd_ready→0.
- **UIR:** 1 period, vs_uir=1. At the TCK rising edge, sample ir_out into the rsp_ir holding register.
  - Next state is RTI if cmd_ir_only=1, otherwise CDR.
- **CDR:** 1 period, vs_cdr=1.
- **SDR:** DR_WIDTH periods, vs_sdr=1, tdi = shift[0].
  - At each TCK rising edge: shift = {tdo, shift[DR_WIDTH-1:1]}.
  - After DR_WIDTH shifts, the shift register holds the tdo bits in arrival order, with the first bit at bit 0.
  - A period counter ($clog2(DR_WIDTH) bits) runs from DR_WIDTH-1 down to 0. SDR exits when the count reaches 0 at the period boundary.
- **UDR:** 1 period, vs_udr=1.
- **RTI:** 1 period, jtag_state_rti=1.
- **DONE:** 1 clk cycle.
  - rsp_valid=1; rsp_dr = shift register (unchanged from the previous value when cmd_ir_only); rsp_ir updated.
  - Then go to IDLE with cmd_ready=1.
- **Held values:**
  - tdi=0 outside SDR.
  - ir_in holds its value from acceptance until the next acceptance; the slave decodes ir_in at UDR.
- **Response handling:** no backpressure on the response; rsp_valid is a pulse.
- **During a command:** cmd_valid is ignored while cmd_ready=0. The cmd_* inputs are sampled only at acceptance.

## Timing
- **Reset values** (while reset=1 and the cycle after): cmd_ready=0, rsp_valid=0, rsp_dr=0, rsp_ir=0, tck=0, tdi=0, ir_in=0, vs_*=0, jtag_state_rti=0, state=IDLE.
- **After reset:** cmd_ready=1 from the first cycle after reset deasserts.
- **Reset mid-command:** the command is aborted with no rsp_valid. All outputs take their reset values on the next clk edge.
- **Full DR command:** the first period starts the cycle after acceptance. It spans (DR_WIDTH+4) periods. rsp_valid is high in cycle (DR_WIDTH+4)*2*TCK_DIV + 1 after the acceptance edge.
  - Defaults: 42 periods, rsp_valid at cycle 337.
- **IR-only command:** 2 periods; rsp_valid at cycle 4*TCK_DIV + 1 (17 at defaults).
- **Back-to-back commands:** cmd_ready rises the cycle after rsp_valid. A command held valid is accepted on that cycle.
  - Minimum gap between transactions: 2 idle cycles (the DONE cycle plus the acceptance cycle).
- **Setup margin:** tdo is sampled TCK_DIV cycles after tdi changes.

## Test plan
- Reset, then idle for 10 cycles → cmd_ready=1, tck=0, all vs_*=0, rsp_valid never asserts.
- cmd_ir=2'b01, cmd_dr=38'h2A_5555_AAAA, slave model returning tdo=tdi (loopback) → vs_sdr high for exactly 38*8 cycles; tck shows 42 rising edges; rsp_valid at cycle 337; rsp_dr=38'h2A_5555_AAAA.
- Slave model driving tdo from a preset 38'h3F_0000_0001 shifted LSB first, ir_out=2'b10 → rsp_dr=38'h3F_0000_0001, rsp_ir=2'b10.
- cmd_ir_only=1, cmd_ir=2'b11 → vs_cdr, vs_sdr and vs_udr never assert; ir_in=2'b11; rsp_valid at cycle 17; rsp_dr unchanged from the previous response.
- cmd_valid held high with two queued commands → the second is accepted exactly 1 cycle after the first rsp_valid; cmd_valid pulses during a busy period are ignored.
- reset asserted during SDR (shift 20 of 38) → the next cycle shows all outputs at their reset values and no rsp_valid; a fresh command afterwards completes normally.

Source files
------------

// File: rtl/de2i_150_qsys_nios2_cpu_debug_jtag_master.sv
// Scripted virtual-JTAG master for the Nios II debug slave: one IR/DR command in,
// full UIR/CDR/SDR/UDR/RTI sequence out on a divided TCK, shifted DR and IR status back.
module de2i_150_qsys_nios2_cpu_debug_jtag_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  input  logic                cmd_ir_only,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int PH_W  = $clog2(2 * TCK_DIV);
  localparam int CNT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(TCK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * TCK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UIR  = 3'd1,
    S_CDR  = 3'd2,
    S_SDR  = 3'd3,
    S_UDR  = 3'd4,
    S_RTI  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PH_W-1:0]     r_phase;
  logic [CNT_W-1:0]    r_cnt;
  logic [DR_WIDTH-1:0] r_shift;
  logic [IR_WIDTH-1:0] r_ir_cap;
  logic [IR_WIDTH-1:0] r_ir_in;
  logic                r_ir_only;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic [DR_WIDTH-1:0] r_rsp_dr;
  logic [IR_WIDTH-1:0] r_rsp_ir;
  logic                r_tck;
  logic                r_tdi;
  logic                r_vs_uir;
  logic                r_vs_cdr;
  logic                r_vs_sdr;
  logic                r_vs_udr;
  logic                r_rti;

  logic w_in_period;
  logic w_rise;
  logic w_end;
  logic w_accept;

  // Period framing: the clk edge that raises tck is where tdo/ir_out are sampled.
  assign w_in_period = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_rise      = w_in_period && (r_phase == PH_RISE);
  assign w_end       = w_in_period && (r_phase == PH_LAST);
  assign w_accept    = cmd_valid && r_cmd_ready;

  // Next-state selection; every transition out of a TCK state lands on a period boundary.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_UIR;
        else          w_state_nxt = S_IDLE;
      end
      S_UIR: begin
        if (w_end) w_state_nxt = r_ir_only ? S_RTI : S_CDR;
        else       w_state_nxt = S_UIR;
      end
      S_CDR: begin
        if (w_end) w_state_nxt = S_SDR;
        else       w_state_nxt = S_CDR;
      end
      S_SDR: begin
        if (w_end && (r_cnt == '0)) w_state_nxt = S_UDR;
        else                        w_state_nxt = S_SDR;
      end
      S_UDR: begin
        if (w_end) w_state_nxt = S_RTI;
        else       w_state_nxt = S_UDR;
      end
      S_RTI: begin
        if (w_end) w_state_nxt = S_DONE;
        else       w_state_nxt = S_RTI;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, TCK generation and state indicators (all decoded from the next state).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_tck       <= 1'b0;
      r_vs_uir    <= 1'b0;
      r_vs_cdr    <= 1'b0;
      r_vs_sdr    <= 1'b0;
      r_vs_udr    <= 1'b0;
      r_rti       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_DONE);
      r_vs_uir    <= (w_state_nxt == S_UIR);
      r_vs_cdr    <= (w_state_nxt == S_CDR);
      r_vs_sdr    <= (w_state_nxt == S_SDR);
      r_vs_udr    <= (w_state_nxt == S_UDR);
      r_rti       <= (w_state_nxt == S_RTI);
      if (w_in_period && !w_end) r_phase <= r_phase + PH_W'(1);
      else                       r_phase <= '0;
      if (w_rise)     r_tck <= 1'b1;
      else if (w_end) r_tck <= 1'b0;
      else            r_tck <= r_tck;
    end
  end

  // Command latch, DR shift path, SDR period counter and response holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_ir_cap  <= '0;
      r_ir_in   <= '0;
      r_ir_only <= 1'b0;
      r_tdi     <= 1'b0;
      r_rsp_dr  <= '0;
      r_rsp_ir  <= '0;
    end else begin
      if (w_accept) begin
        r_shift   <= cmd_dr;
        r_ir_in   <= cmd_ir;
        r_ir_only <= cmd_ir_only;
      end else if ((r_state == S_SDR) && w_rise) begin
        r_shift <= {tdo, r_shift[DR_WIDTH-1:1]};
      end
      if (r_state == S_CDR)                r_cnt <= CNT_LOAD;
      else if ((r_state == S_SDR) && w_end) r_cnt <= r_cnt - CNT_W'(1);
      if ((r_state == S_UIR) && w_rise) r_ir_cap <= ir_out;
      // tdi moves only on period boundaries, so it never changes under a high TCK.
      if (w_state_nxt != S_SDR) r_tdi <= 1'b0;
      else if (w_end)           r_tdi <= r_shift[0];
      if (w_state_nxt == S_DONE) begin
        r_rsp_ir <= r_ir_cap;
        if (!r_ir_only) r_rsp_dr <= r_shift;
      end
    end
  end

  assign cmd_ready      = r_cmd_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_dr         = r_rsp_dr;
  assign rsp_ir         = r_rsp_ir;
  assign tck            = r_tck;
  assign tdi            = r_tdi;
  assign ir_in          = r_ir_in;
  assign vs_uir         = r_vs_uir;
  assign vs_cdr         = r_vs_cdr;
  assign vs_sdr         = r_vs_sdr;
  assign vs_udr         = r_vs_udr;
  assign jtag_state_rti = r_rti;

endmodule
